wheel_encoder_emulator: RTL and testbench

WHEEL_ENCODER_EMULATOR -- requirements
Module: wheel_encoder_emulator

---
 rtl/wheel_encoder_emulator.sv | 91 +++++++++
 tb/tb_wheel_encoder_emulator.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/wheel_encoder_emulator.sv
// wheel_encoder_emulator: quadrature (A,B,Z) wheel encoder emulator; moves of N edges at a fixed period; index via WHEEL_EMU_INDEX_EN
module wheel_encoder_emulator #(
  parameter int PERIOD_W = 16,
  parameter int CPR = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                dir,
  input  logic [7:0]          steps,
  input  logic [PERIOD_W-1:0] period,
  input  logic                stop,
  output logic                A,
  output logic                B,
  output logic                Z,
  output logic                busy,
  output logic                done,
  output logic [7:0]          position
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam logic [PERIOD_W-1:0] ONE = 1;
  logic [1:0] state_q, state_d, ab_q, ab_d, ab_nxt;
  logic dir_q, dir_d, tc, step;
  logic [7:0] rem_q, rem_d, pos_q, pos_d;
  logic [PERIOD_W-1:0] per_q, per_d, cnt_q, cnt_d;
  assign tc = cnt_q == per_q - ONE;
  assign step = state_q == RUN && !stop && tc;
  // {A,B} gray walk: CW 00->10->11->01, CCW the reverse
  assign ab_nxt = dir_q ? {~ab_q[0], ab_q[1]} : {ab_q[0], ~ab_q[1]};
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    rem_d = rem_q;
    per_d = per_q;
    cnt_d = cnt_q;
    ab_d = ab_q;
    pos_d = pos_q;
    case (state_q)
      IDLE: if (start && !stop) begin
        state_d = steps != 8'd0 ? RUN : DONE;
        dir_d = dir;
        rem_d = steps;
        per_d = period == '0 ? ONE : period;
        cnt_d = '0;
      end
      RUN: if (stop) state_d = IDLE;
      else if (tc) begin
        ab_d = ab_nxt;
        pos_d = dir_q ? pos_q + 8'd1 : pos_q - 8'd1;
        rem_d = rem_q - 8'd1;
        cnt_d = '0;
        state_d = rem_q == 8'd1 ? DONE : RUN;
      end else cnt_d = cnt_q + ONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q <= 1'b0;
      rem_q <= '0;
      per_q <= '0;
      cnt_q <= '0;
      ab_q <= 2'b00;
      pos_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      rem_q <= rem_d;
      per_q <= per_d;
      cnt_q <= cnt_d;
      ab_q <= ab_d;
      pos_q <= pos_d;
    end
  end
`ifdef WHEEL_EMU_INDEX_EN
  localparam int RW = CPR > 1 ? $clog2(CPR) : 1;
  localparam logic [RW-1:0] LAST = RW'(CPR - 1);
  logic [RW-1:0] rev_q, rev_d;
  assign rev_d = !step ? rev_q : dir_q ? (rev_q == LAST ? '0 : rev_q + 1'b1) : (rev_q == '0 ? LAST : rev_q - 1'b1);
  always_ff @(posedge clk) rev_q <= reset ? '0 : rev_d;
  assign Z = rev_q == '0 && ab_q == 2'b00;
`else
  assign Z = 1'b0;
`endif
  assign A = ab_q[1];
  assign B = ab_q[0];
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign position = pos_q;
endmodule

// File: tb/tb_wheel_encoder_emulator.sv
// tb_wheel_encoder_emulator: directed self-checking bench for wheel_encoder_emulator
module tb_wheel_encoder_emulator;
  localparam int CPR = 20;
`ifdef WHEEL_EMU_INDEX_EN
  localparam bit IDX = 1'b1;
`else
  localparam bit IDX = 1'b0;
`endif
  logic clk = 1'b0, reset, start, dir, stop, A, B, Z, busy, done;
  logic [7:0] steps, position;
  logic [15:0] period;
  int checks = 0, errors = 0;
  logic [1:0] m_ab;
  logic [7:0] m_pos;
  int m_rev, ne, nb, nd;
  wheel_encoder_emulator #(.PERIOD_W(16), .CPR(CPR)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .steps(steps), .period(period),
    .stop(stop), .A(A), .B(B), .Z(Z), .busy(busy), .done(done), .position(position)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  function automatic logic [1:0] nxt(input logic d, input logic [1:0] ab);
    case ({d, ab})
      3'b100: return 2'b10;
      3'b110: return 2'b11;
      3'b111: return 2'b01;
      3'b101: return 2'b00;
      3'b000: return 2'b01;
      3'b001: return 2'b11;
      3'b011: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction
  task automatic model_reset;
    m_ab = 2'b00;
    m_pos = 8'd0;
    m_rev = 0;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    model_reset;
  endtask
  task automatic move(input logic d, input logic [7:0] s, input logic [15:0] p, input int budget,
                      input int stop_after, input int poke);
    int peff;
    logic [1:0] prev;
    peff = p == 16'd0 ? 1 : int'(p);
    ne = 0; nb = 0; nd = 0;
    prev = {A, B};
    start = 1'b1; dir = d; steps = s; period = p;
    tick;
    start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (busy) nb++;
      if (done) nd++;
      stop = stop_after != 0 && ne >= stop_after;
      if (c == poke) begin
        start = 1'b1;
        steps = 8'd200;
      end
      tick;
      start = 1'b0;
      if ({A, B} != prev) begin
        ne++;
        m_ab = nxt(d, m_ab);
        m_pos = d ? m_pos + 8'd1 : m_pos - 8'd1;
        m_rev = d ? (m_rev == CPR - 1 ? 0 : m_rev + 1) : (m_rev == 0 ? CPR - 1 : m_rev - 1);
        chk("ab_seq", {30'd0, A, B}, {30'd0, m_ab});
        chk("edge_time", c, ne * peff);
        chk("z_edge", Z, IDX && m_rev == 0 && m_ab == 2'b00);
        prev = {A, B};
      end
    end
    stop = 1'b0;
  endtask
  task automatic post(input string tag, input int e_ne, input int e_nb, input int e_nd);
    chk({tag, "_edges"}, ne, e_ne);
    chk({tag, "_busy"}, nb, e_nb);
    chk({tag, "_done"}, nd, e_nd);
    chk({tag, "_pos"}, position, m_pos);
    chk({tag, "_ab"}, {A, B}, m_ab);
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; dir = 1'b0; stop = 1'b0; steps = '0; period = '0;
    do_reset;
    chk("rst_ab", {A, B}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pos", position, 0);
    chk("rst_z", Z, IDX);
    move(1'b1, 8'd8, 16'd4, 40, 0, 0);
    post("cw", 8, 32, 1);
    chk("cw_pos8", position, 8);
    do_reset;
    move(1'b0, 8'd4, 16'd1, 8, 0, 0);
    post("ccw", 4, 4, 0 + 1);
    chk("ccw_pos252", position, 252);
    do_reset;
    move(1'b1, 8'd20, 16'd2, 44, 5, 0);
    post("abort", 5, 11, 0);
    chk("abort_ab10", {A, B}, 2'b10);
    move(1'b1, 8'd1, 16'd3, 8, 0, 0);
    post("after_abort", 1, 3, 1);
    chk("after_abort_ab11", {A, B}, 2'b11);
    move(1'b0, 8'd0, 16'd5, 5, 0, 0);
    post("zero", 0, 0, 1);
    move(1'b1, 8'd3, 16'd0, 8, 0, 0);
    post("per0", 3, 3, 1);
    move(1'b0, 8'd4, 16'd3, 30, 0, 5);
    post("ignore_start", 4, 12, 1);
    start = 1'b1; stop = 1'b1; dir = 1'b1; steps = 8'd3; period = 16'd1;
    tick;
    start = 1'b0; stop = 1'b0;
    tick;
    chk("ss_busy", busy, 0);
    chk("ss_done", done, 0);
    chk("ss_ab", {A, B}, m_ab);
    start = 1'b1; dir = 1'b1; steps = 8'd10; period = 16'd2;
    tick;
    start = 1'b0;
    repeat (5) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    model_reset;
    chk("mid_rst_ab", {A, B}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_pos", position, 0);
    chk("mid_rst_z", Z, IDX);
    tick;
    chk("mid_rst_nodone", done, 0);
    move(1'b1, 8'd20, 16'd1, 24, 0, 0);
    post("index", 20, 20, 1);
    chk("index_z", Z, IDX);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
